// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks every output position of every filter in one conv
// layer, issues window descriptors to a shared MAC engine under a credit limit,
// and turns in-order engine results into output-buffer write addresses.
// Optional feature macro: CONV_LAYER_SCHED_PERF_EN adds perf_cycles/perf_stalls.
module conv_layer_sched #(
   parameter int unsigned KERNEL_SIZE     = 3,
   parameter int unsigned IMGROW          = 7,
   parameter int unsigned IMGCOL          = 7,
   parameter int unsigned STRIDE          = 1,
   parameter int unsigned NUM_FILTERS     = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned OUT_ROWS = (IMGROW - KERNEL_SIZE) / STRIDE + 1,
   localparam int unsigned OUT_COLS = (IMGCOL - KERNEL_SIZE) / STRIDE + 1,
   localparam int unsigned TOTAL    = NUM_FILTERS * OUT_ROWS * OUT_COLS,
   localparam int unsigned FW       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
   localparam int unsigned RW       = (IMGROW > 1) ? $clog2(IMGROW) : 1,
   localparam int unsigned CW       = (IMGCOL > 1) ? $clog2(IMGCOL) : 1,
   localparam int unsigned AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          layer_done,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [FW-1:0] win_filt,
   output logic [RW-1:0] win_row,
   output logic [CW-1:0] win_col,
   input  logic          res_valid,
   output logic          out_we,
   output logic [AW-1:0] out_addr,
   output logic          err
`ifdef CONV_LAYER_SCHED_PERF_EN
   ,
   output logic [31:0]   perf_cycles,
   output logic [31:0]   perf_stalls
`endif
);

   // Counter width must hold TOTAL itself (recv_cnt reaches TOTAL in DRAIN).
   localparam int unsigned NW     = $clog2(TOTAL + 1);
   localparam int unsigned LAST_F = NUM_FILTERS - 1;
   localparam int unsigned LAST_R = (OUT_ROWS - 1) * STRIDE;
   localparam int unsigned LAST_C = (OUT_COLS - 1) * STRIDE;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [NW-1:0]  issue_cnt, recv_cnt, outstanding;
   logic [FW-1:0]  filt;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   logic           err_q;
   logic           credit_ok, last_win, hs, res_ok, start_ok;

   assign outstanding = issue_cnt - recv_cnt;
   assign credit_ok   = 32'(outstanding) < MAX_OUTSTANDING;
   assign last_win    = (filt == FW'(LAST_F)) && (row == RW'(LAST_R)) && (col == CW'(LAST_C));
   assign hs          = win_valid && win_ready;
   assign start_ok    = (state == S_IDLE) && start;
   // A result is only legal while a window is actually in flight in an active layer.
   assign res_ok      = res_valid && ((state == S_ISSUE) || (state == S_DRAIN))
                        && (recv_cnt < NW'(TOTAL)) && (outstanding != '0);

   assign win_filt = filt;
   assign win_row  = row;
   assign win_col  = col;
   assign out_we   = res_ok;
   assign out_addr = AW'(recv_cnt);
   assign err      = err_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      layer_done = 1'b0;
      win_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            busy      = 1'b1;
            win_valid = credit_ok;
            if (credit_ok && win_ready && last_win) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (recv_cnt == NW'(TOTAL)) state_nxt = S_DONE;
         end
         S_DONE: begin
            busy       = 1'b1;
            layer_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Window position walk (col, then row, then filter) and issue/receive counts.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         issue_cnt <= '0;
         recv_cnt  <= '0;
         filt      <= '0;
         row       <= '0;
         col       <= '0;
      end else begin
         if (hs) begin
            issue_cnt <= issue_cnt + NW'(1);
            if (col == CW'(LAST_C)) begin
               col <= '0;
               if (row == RW'(LAST_R)) begin
                  row  <= '0;
                  filt <= (filt == FW'(LAST_F)) ? '0 : filt + FW'(1);
               end else begin
                  row <= row + RW'(STRIDE);
               end
            end else begin
               col <= col + CW'(STRIDE);
            end
         end
         if (res_ok) recv_cnt <= recv_cnt + NW'(1);
      end
   end

   // Sticky protocol error; a dropped result in the same cycle wins over clearing.
   always_ff @(posedge clk) begin
      if (rst)                        err_q <= 1'b0;
      else if (res_valid && !res_ok)  err_q <= 1'b1;
      else if (start_ok)              err_q <= 1'b0;
   end

`ifdef CONV_LAYER_SCHED_PERF_EN
   // Busy-cycle and stall counters; they hold once the layer returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy) perf_cycles <= perf_cycles + 32'd1;
         if ((win_valid && !win_ready) || ((state == S_ISSUE) && !credit_ok))
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench for conv_layer_sched: a window-index reference model
// checked every cycle, plus a STRIDE=2 instance and literal spot checks.
module tb_conv_layer_sched;

   // Default instance geometry
   localparam int OR1 = (7 - 3) / 1 + 1;
   localparam int OC1 = (7 - 3) / 1 + 1;
   localparam int TOT1 = 2 * OR1 * OC1;
   localparam int MAXO = 4;
   // STRIDE=2 instance geometry
   localparam int OR2 = (7 - 3) / 2 + 1;
   localparam int OC2 = (7 - 3) / 2 + 1;
   localparam int TOT2 = 2 * OR2 * OC2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic win_ready = 1'b0;
   logic res_valid = 1'b0;
   logic busy, layer_done, win_valid, out_we, err;
   logic [0:0] win_filt;
   logic [2:0] win_row, win_col;
   logic [5:0] out_addr;

   logic start2 = 1'b0;
   logic res2 = 1'b0;
   logic busy2, done2, wv2, we2, err2;
   logic [0:0] filt2;
   logic [2:0] row2, col2;
   logic [4:0] addr2;

`ifdef CONV_LAYER_SCHED_PERF_EN
   logic [31:0] perf_cycles, perf_stalls, pc2, ps2;
`endif

   always #5 clk = ~clk;

   conv_layer_sched dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .layer_done(layer_done),
      .win_valid(win_valid), .win_ready(win_ready), .win_filt(win_filt),
      .win_row(win_row), .win_col(win_col), .res_valid(res_valid),
      .out_we(out_we), .out_addr(out_addr), .err(err)
`ifdef CONV_LAYER_SCHED_PERF_EN
      , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
   );

   conv_layer_sched #(.STRIDE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .layer_done(done2),
      .win_valid(wv2), .win_ready(1'b1), .win_filt(filt2),
      .win_row(row2), .win_col(col2), .res_valid(res2),
      .out_we(we2), .out_addr(addr2), .err(err2)
`ifdef CONV_LAYER_SCHED_PERF_EN
      , .perf_cycles(pc2), .perf_stalls(ps2)
`endif
   );

   int nvec = 0;
   int nmis = 0;
   int cyc = 0;

   // engine emulation controls
   logic rdy_rand = 1'b0;
   logic rdy_val  = 1'b1;
   int   rel_mode = 1;      // 0 hold results, 1 release when due, 2 release randomly when due
   logic force_res = 1'b0;
   int   lat = 2;
   int   q[$];
   logic hs2_flag = 1'b0;

   // observation counters
   int hs_cnt = 0, we_cnt = 0, done_cnt = 0;
   int sw[64];
   int n2i = 0, n2r = 0, d2_cnt = 0;

   // reference model state
   int ph = 0;              // 0 idle, 1 issuing, 2 draining, 3 done
   int ni = 0, nr = 0;
   logic m_err = 1'b0;
   longint m_pc = 0, m_ps = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // window index -> (filter, top-left row, top-left col)
   function automatic void dec(input int k, input int s, input int orr, input int oc,
                               output int f, output int r, output int c);
      f = k / (orr * oc);
      r = ((k / oc) % orr) * s;
      c = (k % oc) * s;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // engine: drives ready and in-order results away from the clock edge
   always @(posedge clk) begin
      #2;
      win_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
      res_valid = force_res || (rel_mode != 0 && q.size() != 0 && q[0] <= cyc &&
                                (rel_mode == 1 || $urandom_range(0, 2) != 0));
      res2 = hs2_flag;
   end

   // compare against the model, then advance it with this cycle's inputs
   always @(negedge clk) begin : cmp
      int outst, f, r, c;
      logic e_wv, e_we;
      outst = ni - nr;
      e_wv = (ph == 1) && (outst < MAXO);
      e_we = res_valid && (ph == 1 || ph == 2) && (nr < TOT1) && (outst != 0);
      chk("busy", busy, ph != 0);
      chk("layer_done", layer_done, ph == 3);
      chk("win_valid", win_valid, e_wv);
      chk("out_we", out_we, e_we);
      chk("err", err, m_err);
      if (e_wv) begin
         dec(ni, 1, OR1, OC1, f, r, c);
         chk("win_filt", win_filt, f);
         chk("win_row", win_row, r);
         chk("win_col", win_col, c);
      end
      if (e_we) chk("out_addr", out_addr, nr);
`ifdef CONV_LAYER_SCHED_PERF_EN
      chk("perf_cycles", perf_cycles, m_pc);
      chk("perf_stalls", perf_stalls, m_ps);
`endif
      // engine bookkeeping: retire before enqueue so a same-cycle issue is not consumed
      if (res_valid && q.size() != 0) void'(q.pop_front());
      if (win_valid && win_ready) begin
         if (hs_cnt < 64) sw[hs_cnt] = 100 * int'(win_filt) + 10 * int'(win_row) + int'(win_col);
         hs_cnt++;
         q.push_back(cyc + lat);
      end
      if (out_we) we_cnt++;
      if (layer_done) done_cnt++;

      // STRIDE=2 instance: always ready, result one cycle after each issue
      if (wv2) begin
         chk("s2_in_range", n2i < TOT2, 1);
         dec(n2i, 2, OR2, OC2, f, r, c);
         chk("s2_filt", filt2, f);
         chk("s2_row", row2, r);
         chk("s2_col", col2, c);
         n2i++;
      end
      hs2_flag = wv2;
      if (we2) begin
         chk("s2_addr", addr2, n2r);
         n2r++;
      end
      if (done2) d2_cnt++;

      // model advance
      if (rst) begin
         ph = 0; ni = 0; nr = 0; m_err = 1'b0; m_pc = 0; m_ps = 0;
         q.delete();
      end else begin
         if (ph == 0 && start) begin
            m_pc = 0; m_ps = 0;
         end else begin
            if (ph != 0) m_pc++;
            if ((e_wv && !win_ready) || (ph == 1 && !e_wv)) m_ps++;
         end
         if (res_valid && !e_we) m_err = 1'b1;
         else if (ph == 0 && start) m_err = 1'b0;
         case (ph)
            0: if (start) begin ph = 1; ni = 0; nr = 0; end
            1: if (e_wv && win_ready) begin
                  ni++;
                  if (ni == TOT1) ph = 2;
               end
            2: if (nr == TOT1) ph = 3;
            default: ph = 0;
         endcase
         if (e_we) nr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         n++;
      end
      chk(nm, done_cnt, target);
      tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      tick();

      // Layer 1: always ready, result two cycles after each issue; STRIDE=2 unit alongside
      hs_cnt = 0; we_cnt = 0; done_cnt = 0;
      start2 = 1'b1;
      pulse_start();
      start2 = 1'b0;
      wait_done(1, 400, "t1_done");
      chk("t1_handshakes", hs_cnt, 50);
      chk("t1_writes", we_cnt, 50);
      chk("t1_err", err, 0);
      chk("t1_win_1", sw[1], 1);
      chk("t1_win_5", sw[5], 10);
      chk("t1_win_49", sw[49], 144);
      chk("s2_issued", n2i, 18);
      chk("s2_written", n2r, 18);
      chk("s2_done", d2_cnt, 1);
      chk("s2_err", err2, 0);

      // Credit limit: results withheld, then released one at a time
      hs_cnt = 0; done_cnt = 0; rel_mode = 0;
      pulse_start();
      repeat (10) tick();
      chk("credit_hs", hs_cnt, 4);
      chk("credit_blocked", win_valid, 0);
      rel_mode = 1;
      tick();
      rel_mode = 0;
      repeat (6) tick();
      chk("credit_one_more", hs_cnt, 5);
      rel_mode = 1;
      wait_done(1, 400, "credit_done");

      // Random ready and random result timing over two layers
      rdy_rand = 1'b1; rel_mode = 2;
      for (int l = 0; l < 2; l++) begin
         done_cnt = 0; hs_cnt = 0; we_cnt = 0;
         pulse_start();
         wait_done(1, 3000, "rand_done");
         chk("rand_handshakes", hs_cnt, 50);
         chk("rand_writes", we_cnt, 50);
      end
      rdy_rand = 1'b0; rel_mode = 1;

      // Reset in the middle of a layer
      hs_cnt = 0; done_cnt = 0;
      pulse_start();
      begin
         int n = 0;
         while (hs_cnt < 10 && n < 100) begin tick(); n++; end
         chk("rstmid_reached", hs_cnt >= 10, 1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #3;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_win_valid", win_valid, 0);
      chk("rstmid_layer_done", layer_done, 0);
      repeat (5) tick();
      chk("rstmid_no_done", done_cnt, 0);
      pulse_start();
      #3;
      chk("restart_valid", win_valid, 1);
      chk("restart_filt", win_filt, 0);
      chk("restart_row", win_row, 0);
      chk("restart_col", win_col, 0);
      wait_done(1, 400, "restart_done");

      // Protocol errors: result in IDLE, result with nothing outstanding
      force_res = 1'b1;
      tick();
      force_res = 1'b0;
      #3;
      chk("err_idle", err, 1);
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      force_res = 1'b1;
      #3;
      chk("err_cleared_by_start", err, 0);
      tick();
      force_res = 1'b0;
      #3;
      chk("err_no_outstanding", err, 1);
      wait_done(1, 400, "err_layer_done");
      chk("err_sticky", err, 1);
      pulse_start();
      #3;
      chk("err_cleared_again", err, 0);
      done_cnt = 0;
      wait_done(1, 400, "final_done");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Sequencer that drives a shared convolution MAC engine over every output position of every filter in one conv layer.
- Issues window descriptors (filter index, top-left row/col) over a valid/ready handshake.
- Bounds in-flight windows with a credit counter and collects in-order results into output-buffer write addresses.
- Signals layer completion to the layer-level control path with a one-cycle layer_done pulse.

Parameters:
- KERNEL_SIZE, 3, square kernel edge length.
- IMGROW, 7, input image rows.
- IMGCOL, 7, input image columns.
- STRIDE, 1, window step in both dimensions; must be >=1.
- NUM_FILTERS, 2, kernels applied per layer.
- MAX_OUTSTANDING, 4, max windows issued but not yet returned; must be >=1.
- Derived values:
  - OUT_ROWS = (IMGROW-KERNEL_SIZE)/STRIDE+1.
  - OUT_COLS = (IMGCOL-KERNEL_SIZE)/STRIDE+1.
  - TOTAL = NUM_FILTERS*OUT_ROWS*OUT_COLS.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a layer; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- layer_done  out  1  one-cycle pulse after the last result is written.
- win_valid  out  1  window descriptor valid.
- win_ready  in  1  engine accepts the descriptor.
- win_filt  out  clog2(NUM_FILTERS) max 1  filter index.
- win_row  out  clog2(IMGROW)  top-left image row = out_row*STRIDE.
- win_col  out  clog2(IMGCOL)  top-left image column = out_col*STRIDE.
- res_valid  in  1  engine result strobe; results arrive in issue order.
- out_we  out  1  output-buffer write enable.
- out_addr  out  clog2(TOTAL)  write address, filter-major then row then column.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: state IDLE. All counters are 0. busy, layer_done, win_valid, out_we and err are 0. win_filt, win_row, win_col and out_addr are 0.
- States and transitions:
  - IDLE: start=1 -> ISSUE. The next cycle shows win_valid=1 with (0,0,0).
  - ISSUE: handshake = win_valid&&win_ready. Each handshake advances col, then row on col wrap, then filter on row wrap. The handshake on the final window (NUM_FILTERS-1, last row, last col) -> DRAIN.
  - DRAIN: win_valid=0. Waits for recv_cnt==TOTAL, then -> DONE.
  - DONE: layer_done=1 for exactly one cycle -> IDLE.
- win_valid in ISSUE is 1 iff outstanding < MAX_OUTSTANDING, where outstanding = issue_cnt - recv_cnt.
- Descriptor stability: win_filt, win_row and win_col hold stable while win_valid=1 and win_ready=0. win_valid never drops without a handshake, except when entering DRAIN.
- Result path:
  - out_we = res_valid combinationally while busy and recv_cnt<TOTAL.
  - out_addr = recv_cnt; recv_cnt increments on each accepted result.
- Results may arrive during ISSUE. A handshake and a result in the same cycle leave outstanding unchanged.
- Error cases (err goes sticky):
  - res_valid in IDLE or DONE: err=1, the result is dropped, out_we=0.
  - res_valid with recv_cnt==TOTAL: err=1, the result is dropped, out_we=0.
  - res_valid with outstanding==0: err=1, the result is dropped, out_we=0.
- err clears only on rst or on an accepted start.
- start while busy is ignored.
- Reset mid-operation: immediate return to IDLE with all counters cleared. No layer_done pulse is produced.
- Counters wide enough for TOTAL; no wrap beyond TOTAL occurs.

Optional Feature:
- Macro: CONV_LAYER_SCHED_PERF_EN.
- When defined, adds two outputs:
  - perf_cycles (32 bit): counts cycles with busy=1.
  - perf_stalls (32 bit): counts cycles where win_valid=1&&win_ready=0, or where ISSUE is credit-blocked.
- Both counters clear on an accepted start and on rst, and hold their values after DONE.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults (TOTAL=50); win_ready=1 always; res_valid 2 cycles after each handshake -> 50 descriptors in order: (0,0,0),(0,0,1)..(0,0,4),(0,1,0)..(1,4,4). out_addr runs 0..49. One layer_done pulse; err=0.
- STRIDE=2, IMGROW=IMGCOL=7 -> OUT 3x3 per filter; win_row/win_col take values {0,2,4}; TOTAL=18 writes.
- MAX_OUTSTANDING=4 with results withheld -> exactly 4 handshakes, then win_valid=0. Releasing one result -> exactly one further handshake.
- win_ready toggled randomly -> descriptor stable during stalls; no duplicate or skipped window; with PERF_EN, perf_stalls equals the stall-cycle count.
- rst asserted after 10 handshakes -> next cycle busy=0, win_valid=0, no layer_done. A new start reissues (0,0,0).
- res_valid pulse in IDLE -> err=1, out_we=0. A subsequent start clears err.
